// File: rtl/slot_pkg.sv
// Shared types, geometry and palette for the slot reel renderer.
// Widths here assume the default 8-symbol, 64-row, 512-row strip.
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        STOPPING
    } reel_state_t;

    localparam int OFF_W = 9;
    localparam int LX_W  = 7;

    localparam logic [10:0] WIN_X0    = 11'd96;
    localparam logic [10:0] WIN_PITCH = 11'd160;
    localparam logic [10:0] WIN_W     = 11'd128;
    localparam logic [9:0]  WIN_Y0    = 10'd144;
    localparam logic [9:0]  WIN_Y1    = 10'd335;
    localparam logic [9:0]  TICK_LINE = 10'd480;

    localparam logic [11:0] BG_COLOR     = 12'h040;
    localparam logic [11:0] BORDER_COLOR = 12'h000;
    localparam logic [11:0] FILL_COLOR   = 12'hFFF;

    localparam logic [5:0]      LY_MIN = 6'd2;
    localparam logic [5:0]      LY_MAX = 6'd61;
    localparam logic [LX_W-1:0] LX_MIN = 7'd2;
    localparam logic [LX_W-1:0] LX_MAX = 7'd125;
    localparam logic [5:0]      IN_Y0  = 6'd8;
    localparam logic [5:0]      IN_Y1  = 6'd55;
    localparam logic [LX_W-1:0] IN_X0  = 7'd32;
    localparam logic [LX_W-1:0] IN_X1  = 7'd95;

    function automatic logic [10:0] win_x0(input int idx);
        return WIN_X0 + 11'(idx) * WIN_PITCH;
    endfunction

    function automatic logic [11:0] sym_color(input logic [2:0] sym);
        logic [11:0] c;
        case (sym)
            3'd0:    c = 12'hF00;
            3'd1:    c = 12'hF80;
            3'd2:    c = 12'hFF0;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'h0FF;
            3'd5:    c = 12'h00F;
            3'd6:    c = 12'hF0F;
            default: c = 12'h888;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/slot_reel_renderer_reel_ctrl.sv
// One reel: spin/stop state machine, frame counter, latched target, strip offset.
// Offset moves only on frame ticks; start is taken only while idle, no backpressure.
module reel_ctrl
    import slot_pkg::*;
#(
    parameter int REEL_IDX        = 0,
    parameter int NUM_SYMS        = 8,
    parameter int SYM_H           = 64,
    parameter int SPIN_SPEED      = 8,
    parameter int MIN_SPIN_FRAMES = 60,
    parameter int STAGGER_FRAMES  = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        start,
    input  logic [$clog2(NUM_SYMS)-1:0] target,
    output logic [OFF_W-1:0]            offset,
    output logic                        idle
);

    localparam int SYM_W = $clog2(NUM_SYMS);
    localparam int ROW_W = $clog2(SYM_H);
    localparam int LIMIT = MIN_SPIN_FRAMES + REEL_IDX * STAGGER_FRAMES;
    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    reel_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [SYM_W-1:0] tgt, tgt_n;
    logic [OFF_W-1:0] offset_n, adv, stop_off;

    assign adv     = offset + OFF_W'(SPIN_SPEED);
    assign cnt_inc = cnt + CNT_W'(1);
    // Parking one cell above the target puts the target on the centre payline.
    assign stop_off = {tgt - SYM_W'(1), {ROW_W{1'b0}}};
    assign idle     = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            tgt    <= '0;
            offset <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tgt    <= tgt_n;
            offset <= offset_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tgt_n    = tgt;
        offset_n = offset;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SPIN;
                    cnt_n   = '0;
                    tgt_n   = target;
                end
            end
            SPIN: begin
                if (tick) begin
                    offset_n = adv;
                    cnt_n    = cnt_inc;
                    if (cnt_inc == LIMIT_V) state_n = STOPPING;
                end
            end
            STOPPING: begin
                if (tick) begin
                    offset_n = adv;
                    if (adv == stop_off) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/slot_reel_renderer.sv
// Draws three scrolling slot reels over the VGA raster and runs their spin control.
// Latency 2 cycles from raster/sync inputs to outputs; no backpressure, spin_start ignored while busy.
module slot_reel_renderer
    import slot_pkg::*;
#(
    parameter int NUM_REELS       = 3,
    parameter int NUM_SYMS        = 8,
    parameter int SYM_H           = 64,
    parameter int SPIN_SPEED      = 8,
    parameter int MIN_SPIN_FRAMES = 60,
    parameter int STAGGER_FRAMES  = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            hcount,
    input  logic [9:0]             vcount,
    input  logic                   active_video,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   spin_start,
    input  logic [NUM_REELS*3-1:0] target_sym,
    output logic [11:0]            rgb,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   active_out,
    output logic                   busy,
    output logic                   done
);

    localparam int SYM_W = $clog2(NUM_SYMS);
    localparam int ROW_W = $clog2(SYM_H);

    logic                               tick, accept, busy_q;
    logic [NUM_REELS-1:0]               reel_idle;
    logic [NUM_REELS-1:0][OFF_W-1:0]    offsets;

    assign tick   = (hcount == '0) && (vcount == TICK_LINE);
    assign busy   = ~&reel_idle;
    assign accept = spin_start & ~busy;
    assign done   = &reel_idle & busy_q;

    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        reel_ctrl #(
            .REEL_IDX       (i),
            .NUM_SYMS       (NUM_SYMS),
            .SYM_H          (SYM_H),
            .SPIN_SPEED     (SPIN_SPEED),
            .MIN_SPIN_FRAMES(MIN_SPIN_FRAMES),
            .STAGGER_FRAMES (STAGGER_FRAMES)
        ) u_reel (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .start (accept),
            .target(target_sym[SYM_W*i +: SYM_W]),
            .offset(offsets[i]),
            .idle  (reel_idle[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= 1'b0;
        else       busy_q <= busy;
    end

    // Stage 1: window hit, cell-local column and strip row.
    logic             hit_c, row_hit;
    logic [LX_W-1:0]  lx_c;
    logic [OFF_W-1:0] ypos_c;

    assign row_hit = (vcount >= WIN_Y0) && (vcount <= WIN_Y1);

    always_comb begin
        hit_c  = 1'b0;
        lx_c   = '0;
        ypos_c = '0;
        for (int i = 0; i < NUM_REELS; i++) begin
            if (row_hit && hcount >= win_x0(i) && hcount < win_x0(i) + WIN_W) begin
                hit_c  = 1'b1;
                lx_c   = LX_W'(hcount - win_x0(i));
                ypos_c = OFF_W'(vcount - WIN_Y0) + offsets[i];
            end
        end
    end

    logic             s1_hit, s1_active, s1_hsync, s1_vsync;
    logic [LX_W-1:0]  s1_lx;
    logic [OFF_W-1:0] s1_ypos;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit    <= 1'b0;
            s1_lx     <= '0;
            s1_ypos   <= '0;
            s1_active <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
        end else begin
            s1_hit    <= hit_c;
            s1_lx     <= lx_c;
            s1_ypos   <= ypos_c;
            s1_active <= active_video;
            s1_hsync  <= hsync;
            s1_vsync  <= vsync;
        end
    end

    // Stage 2: colour by priority.
    logic [ROW_W-1:0] ly;
    logic [SYM_W-1:0] sym;
    logic             border, inner;
    logic [11:0]      pix_c;

    assign ly     = s1_ypos[ROW_W-1:0];
    assign sym    = s1_ypos[OFF_W-1:ROW_W];
    assign border = (ly < LY_MIN) || (ly > LY_MAX) || (s1_lx < LX_MIN) || (s1_lx > LX_MAX);
    assign inner  = (ly >= IN_Y0) && (ly <= IN_Y1) && (s1_lx >= IN_X0) && (s1_lx <= IN_X1);

    always_comb begin
        pix_c = FILL_COLOR;
        if (!s1_active)   pix_c = 12'h000;
        else if (!s1_hit) pix_c = BG_COLOR;
        else if (border)  pix_c = BORDER_COLOR;
        else if (inner)   pix_c = sym_color(sym);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb        <= '0;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
            active_out <= 1'b0;
        end else begin
            rgb        <= pix_c;
            hsync_out  <= s1_hsync;
            vsync_out  <= s1_vsync;
            active_out <= s1_active;
        end
    end

endmodule

// File: tb/tb_slot_reel_renderer.sv
// Randomised bench for slot_reel_renderer against a frame/pixel model built from the reel rules.
// Frame ticks are forced by driving hcount=0, vcount=480 for single cycles.
module tb_slot_reel_renderer;

    logic        clk = 1'b0;
    logic        reset, active_video, hsync, vsync, spin_start;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [8:0]  target_sym;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, active_out, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int model_off [3] = '{0, 0, 0};
    int stop_at [3];
    logic busy_after_start, done_at_stop, busy_at_stop, done_after;
    logic [11:0] pal [8] = '{12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
                             12'h0FF, 12'h00F, 12'hF0F, 12'h888};

    slot_reel_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .active_video(active_video),
        .hsync       (hsync),
        .vsync       (vsync),
        .spin_start  (spin_start),
        .target_sym  (target_sym),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .active_out  (active_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Offset after k ticks is off0 + 8k (mod 512); the reel parks on the first
    // tick after its spin limit that lands one cell above the target.
    function automatic int exp_stop(int reel, int off0, int tgt);
        int limit = 60 + 30 * reel;
        int want  = ((tgt + 7) % 8) * 64;
        for (int k = limit + 1; k <= limit + 64; k++)
            if ((off0 + 8 * k) % 512 == want) return k;
        return -1;
    endfunction

    function automatic int exp_final(int tgt);
        return ((tgt + 7) % 8) * 64;
    endfunction

    function automatic logic [11:0] ref_pixel(int x, int y, bit act);
        if (!act) return 12'h000;
        for (int i = 0; i < 3; i++) begin
            int x0 = 96 + 160 * i;
            if (x >= x0 && x < x0 + 128 && y >= 144 && y < 336) begin
                int lx   = x - x0;
                int ypos = (y - 144 + model_off[i]) % 512;
                int ly   = ypos % 64;
                int sym  = ypos / 64;
                if (ly < 2 || ly > 61 || lx < 2 || lx > 125) return 12'h000;
                if (ly >= 8 && ly <= 55 && lx >= 32 && lx <= 95) return pal[sym];
                return 12'hFFF;
            end
        end
        return 12'h040;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hcount = 11'd1; vcount = 10'd0;
        active_video = 1'b0; hsync = 1'b1; vsync = 1'b1;
    endtask

    task automatic do_tick();
        hcount = 11'd0; vcount = 10'd480;
        step();
        hcount = 11'd1; vcount = 10'd0;
    endtask

    // Starts a spin and ticks frames until every reel is idle (or abort_at is hit).
    task automatic spin_run(input logic [8:0] tg, input bit poke, input int abort_at);
        stop_at = '{0, 0, 0};
        done_at_stop = 1'b0; busy_at_stop = 1'b1; done_after = 1'b1;
        target_sym = tg; spin_start = 1'b1;
        step();
        spin_start = 1'b0;
        busy_after_start = busy;
        target_sym = 9'($urandom);
        for (int k = 1; k <= 400; k++) begin
            if (poke && (k == 20 || k == 70)) begin
                target_sym = 9'($urandom); spin_start = 1'b1;
                step();
                spin_start = 1'b0;
            end
            do_tick();
            for (int i = 0; i < 3; i++)
                if (stop_at[i] == 0 && dut.reel_idle[i] === 1'b1) stop_at[i] = k;
            if (k == abort_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                return;
            end
            if (stop_at[0] != 0 && stop_at[1] != 0 && stop_at[2] != 0) begin
                done_at_stop = done; busy_at_stop = busy;
                step();
                done_after = done;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; spin_start = 1'b0; target_sym = '0;
        hcount = 11'd0; vcount = 10'd0; active_video = 1'b1; hsync = 1'b0; vsync = 1'b0;
        step(); step();
        n_tests++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb); end
        n_tests++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hsync_out); end
        n_tests++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vsync_out); end
        n_tests++; if (active_out !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dut.offsets[i] !== 9'd0) begin n_fail++; $display("FAIL reset_offset%0d: got %0d want 0", i, dut.offsets[i]); end
        end
        reset = 1'b0;
        step(); step();
        n_tests++; if (rgb !== 12'h040) begin n_fail++; $display("FAIL reset_bg: got %h want 040", rgb); end
        n_tests++; if (active_out !== 1'b1) begin n_fail++; $display("FAIL reset_active_pass: got %b want 1", active_out); end
        n_tests++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_hsync_pass: got %b want 0", hsync_out); end
        idle_inputs();
    endtask

    task automatic test_static_image();
        active_video = 1'b1;
        hcount = 11'd160; vcount = 10'd216; step(); step();
        n_tests++; if (rgb !== 12'hF80) begin n_fail++; $display("FAIL static_sym1: got %h want F80", rgb); end
        hcount = 11'd96; vcount = 10'd144; step(); step();
        n_tests++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL static_border: got %h want 000", rgb); end
        hcount = 11'd100; vcount = 10'd150; step(); step();
        n_tests++; if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL static_fill: got %h want FFF", rgb); end
        idle_inputs();
    endtask

    task automatic test_pipeline_alignment();
        logic [2:0] q [$];
        logic [2:0] p, e;
        for (int j = 0; j < 60; j++) begin
            p = 3'($urandom);
            hsync = p[2]; vsync = p[1]; active_video = p[0];
            hcount = 11'($urandom_range(1, 799)); vcount = 10'($urandom_range(0, 479));
            q.push_back(p);
            step();
            if (q.size() == 2) begin
                e = q.pop_front();
                n_tests++;
                if ({hsync_out, vsync_out, active_out} !== e) begin
                    n_fail++;
                    $display("FAIL align: got %b want %b", {hsync_out, vsync_out, active_out}, e);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random_pixels(input int n, input string tag);
        logic [11:0] q [$];
        logic [11:0] e;
        int x, y;
        bit act;
        for (int j = 0; j < n; j++) begin
            x = $urandom_range(0, 799);
            y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 524) : $urandom_range(140, 340);
            if (x == 0 && y == 480) x = 1;
            act = ($urandom_range(0, 7) != 0);
            hcount = 11'(x); vcount = 10'(y); active_video = act;
            q.push_back(ref_pixel(x, y, act));
            step();
            if (q.size() == 2) begin
                e = q.pop_front();
                n_tests++;
                if (rgb !== e) begin n_fail++; $display("FAIL pixel_%s: got %h want %h", tag, rgb, e); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_full_spin();
        int tg [3] = '{3, 5, 7};
        int es [3];
        int d0;
        for (int i = 0; i < 3; i++) es[i] = exp_stop(i, model_off[i], tg[i]);
        d0 = done_cnt;
        spin_run({3'(tg[2]), 3'(tg[1]), 3'(tg[0])}, 1'b0, 0);
        n_tests++; if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL spin_busy_rise: got %b want 1", busy_after_start); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (stop_at[i] != es[i]) begin n_fail++; $display("FAIL spin_stop%0d: got tick %0d want %0d", i, stop_at[i], es[i]); end
            n_tests++;
            if (dut.offsets[i] !== 9'(exp_final(tg[i]))) begin
                n_fail++; $display("FAIL spin_offset%0d: got %0d want %0d", i, dut.offsets[i], exp_final(tg[i]));
            end
            model_off[i] = exp_final(tg[i]);
        end
        n_tests++; if (done_at_stop !== 1'b1) begin n_fail++; $display("FAIL spin_done: got %b want 1", done_at_stop); end
        n_tests++; if (busy_at_stop !== 1'b0) begin n_fail++; $display("FAIL spin_busy_fall: got %b want 0", busy_at_stop); end
        n_tests++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL spin_done_width: got %b want 0", done_after); end
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL spin_done_count: got %0d want 1", done_cnt - d0); end
        for (int i = 0; i < 3; i++) begin
            hcount = 11'(136 + 160 * i); vcount = 10'd216; active_video = 1'b1;
            step(); step();
            n_tests++;
            if (rgb !== pal[tg[i]]) begin n_fail++; $display("FAIL payline%0d: got %h want %h", i, rgb, pal[tg[i]]); end
        end
        idle_inputs();
    endtask

    task automatic test_ignored_request();
        int tg [3];
        int es [3];
        int d0;
        for (int i = 0; i < 3; i++) begin
            tg[i] = $urandom_range(0, 7);
            es[i] = exp_stop(i, model_off[i], tg[i]);
        end
        d0 = done_cnt;
        spin_run({3'(tg[2]), 3'(tg[1]), 3'(tg[0])}, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (stop_at[i] != es[i]) begin n_fail++; $display("FAIL ignore_stop%0d: got tick %0d want %0d", i, stop_at[i], es[i]); end
            n_tests++;
            if (dut.offsets[i] !== 9'(exp_final(tg[i]))) begin
                n_fail++; $display("FAIL ignore_offset%0d: got %0d want %0d", i, dut.offsets[i], exp_final(tg[i]));
            end
            model_off[i] = exp_final(tg[i]);
        end
        n_tests++; if (done_at_stop !== 1'b1) begin n_fail++; $display("FAIL ignore_done: got %b want 1", done_at_stop); end
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_spin();
        int d0 = done_cnt;
        spin_run(9'($urandom), 1'b0, 40);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dut.offsets[i] !== 9'd0) begin n_fail++; $display("FAIL abort_offset%0d: got %0d want 0", i, dut.offsets[i]); end
            model_off[i] = 0;
        end
        for (int j = 0; j < 5; j++) step();
        n_tests++; if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_restart();
        int tg [3];
        int es [3];
        int d0;
        for (int i = 0; i < 3; i++) begin
            tg[i] = $urandom_range(0, 7);
            es[i] = exp_stop(i, model_off[i], tg[i]);
        end
        d0 = done_cnt;
        spin_run({3'(tg[2]), 3'(tg[1]), 3'(tg[0])}, 1'b0, 0);
        n_tests++; if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", busy_after_start); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (stop_at[i] != es[i]) begin n_fail++; $display("FAIL restart_stop%0d: got tick %0d want %0d", i, stop_at[i], es[i]); end
            model_off[i] = exp_final(tg[i]);
        end
        n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_static_image();
        test_pipeline_alignment();
        test_random_pixels(200, "zero");
        test_full_spin();
        test_random_pixels(200, "spun");
        test_ignored_request();
        test_reset_mid_spin();
        test_restart();
        test_random_pixels(200, "restart");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
